spi_reg_ctrl: RTL and testbench

Command sequencer between the SPI slave byte engine and a small on-chip register file. It decodes a command byte from each SPI frame, then performs single or burst register reads and writes. For each byte the slave clocks out, it stages the response byte on the slave's transmit input. Registers 0 and 1 are exported to drive the 7-segment displays and LEDs at top level.

---
 rtl/spi_reg_ctrl_if.sv | 11 +
 rtl/spi_reg_ctrl.sv | 121 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave engine and the register command sequencer.
// The master side is the SPI byte engine; the slave side is the sequencer.
interface spi_reg_ctrl_if;
    logic       ss;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    modport master (output ss, output rx_done, output rx_byte, input tx_byte);
    modport slave  (input ss, input rx_done, input rx_byte, output tx_byte);
endinterface

// File: rtl/spi_reg_ctrl.sv
// Command sequencer: decodes the first byte of each SPI frame, then performs
// burst register reads/writes and stages the next response byte on tx_byte.
module spi_reg_ctrl #(
    parameter int         NREGS  = 16,
    parameter logic [7:0] STATUS = 8'hA5,
    parameter logic [7:0] DEV_ID = 8'h3C
) (
    input  logic              clk,
    input  logic              rst,
    spi_reg_ctrl_if.slave     spi,
    output logic [7:0]        reg0_q,
    output logic [7:0]        reg1_q,
    output logic              wr_pulse,
    output logic              busy,
    output logic              err
);
    localparam int            AW      = $clog2(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
    localparam logic [AW-1:0] CLR_REG = AW'(NREGS - 2);

    localparam logic [1:0] ST_CMD   = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    tx_q, tx_d;
    logic          err_q, err_d;
    logic          wr_pulse_q;
    logic          rx_done_q;
    logic          rx_edge;
    logic          wr_en;
    logic [7:0]    rf [NREGS];

    assign rx_edge = spi.rx_done & ~rx_done_q;
    // Frame end wins over a byte completing in the same cycle, so gate writes on ss.
    assign wr_en   = ~spi.ss & rx_edge & (state_q == ST_WDATA) & (addr_q != LAST);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == NREGS - 1) begin : g_id
            assign rf[gi] = DEV_ID;
        end else begin : g_rw
            logic [7:0] r_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (wr_en && addr_q == AW'(gi)) begin
                    r_q <= spi.rx_byte;
                end
            end
            assign rf[gi] = r_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        err_d   = err_q;
        if (spi.ss) begin
            state_d = ST_CMD;
            tx_d    = STATUS;
        end else if (rx_edge) begin
            case (state_q)
                ST_CMD: begin
                    if (spi.rx_byte[6:4] != 3'b000) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                        tx_d    = 8'hEE;
                    end else begin
                        addr_d = spi.rx_byte[AW-1:0];
                        if (spi.rx_byte[7]) begin
                            state_d = ST_WDATA;
                            tx_d    = 8'h00;
                        end else begin
                            state_d = ST_RDATA;
                            tx_d    = rf[spi.rx_byte[AW-1:0]];
                        end
                    end
                end
                ST_WDATA: begin
                    addr_d = addr_q + 1'b1;
                    if (wr_en && addr_q == CLR_REG && spi.rx_byte == 8'h00) begin
                        err_d = 1'b0;
                    end
                end
                ST_RDATA: begin
                    addr_d = addr_q + 1'b1;
                    tx_d   = rf[addr_q + 1'b1];
                end
                default: tx_d = 8'hEE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CMD;
            addr_q     <= '0;
            tx_q       <= STATUS;
            err_q      <= 1'b0;
            wr_pulse_q <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            err_q      <= err_d;
            wr_pulse_q <= wr_en;
            rx_done_q  <= spi.rx_done;
        end
    end

    assign spi.tx_byte = tx_q;
    assign reg0_q      = rf[0];
    assign reg1_q      = rf[1];
    assign wr_pulse    = wr_pulse_q;
    assign busy        = (state_q != ST_CMD);
    assign err         = err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: byte-level frame model compared every cycle, plus
// directed literal checks and randomized frames.
module tb_spi_reg_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] reg0_q, reg1_q;
    logic       wr_pulse, busy, err;

    spi_reg_ctrl_if spi_if ();

    spi_reg_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (spi_if),
        .reg0_q   (reg0_q),
        .reg1_q   (reg1_q),
        .wr_pulse (wr_pulse),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    logic chk_en = 1'b0;

    // Frame-level model: register array, byte index within the frame, command.
    logic [7:0] mreg [16];
    int         m_idx;
    logic [7:0] m_cmd;
    logic [3:0] m_addr;
    logic [7:0] exp_tx;
    logic       exp_err, exp_wr, exp_busy;

    function automatic logic [7:0] rd(input logic [3:0] a);
        return (a == 4'd15) ? 8'h3C : mreg[a];
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        m_idx = 0; m_cmd = 8'h00; m_addr = 4'd0;
        exp_tx = 8'hA5; exp_err = 1'b0; exp_wr = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic model_end();
        exp_tx = 8'hA5; exp_busy = 1'b0; exp_wr = 1'b0; m_idx = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_idx == 0) begin
            m_cmd = b;
            if (b[6:4] != 3'b000) begin
                exp_err = 1'b1;
                exp_tx  = 8'hEE;
            end else begin
                m_addr = b[3:0];
                exp_tx = b[7] ? 8'h00 : rd(m_addr);
            end
        end else if (m_cmd[6:4] == 3'b000) begin
            if (m_cmd[7]) begin
                if (m_addr != 4'd15) begin
                    mreg[m_addr] = b;
                    exp_wr = 1'b1;
                    if (m_addr == 4'd14 && b == 8'h00) exp_err = 1'b0;
                end
                m_addr = m_addr + 4'd1;
            end else begin
                m_addr = m_addr + 4'd1;
                exp_tx = rd(m_addr);
            end
        end
        m_idx++;
        exp_busy = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_byte", spi_if.tx_byte, exp_tx);
            check("reg0_q", reg0_q, mreg[0]);
            check("reg1_q", reg1_q, mreg[1]);
            check("busy", {7'd0, busy}, {7'd0, exp_busy});
            check("err", {7'd0, err}, {7'd0, exp_err});
            check("wr_pulse", {7'd0, wr_pulse}, {7'd0, exp_wr});
        end
        if (wr_pulse === 1'b1) wr_cnt++;
    end

    // All tasks below start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        spi_if.rx_byte = b;
        spi_if.rx_done = 1'b1;
        @(posedge clk); #1;
        model_byte(b);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            exp_wr = 1'b0;
        end
        spi_if.rx_done = 1'b0;
        spi_if.rx_byte = 8'($urandom);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            exp_wr = 1'b0;
        end
    endtask

    task automatic sb(input logic [7:0] b);
        send_byte(b, int'($urandom_range(1, 4)), int'($urandom_range(2, 4)));
    endtask

    task automatic frame_start();
        spi_if.ss = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic frame_end();
        spi_if.ss = 1'b1;
        @(posedge clk); #1;
        model_end();
        @(posedge clk); #1;
    endtask

    task automatic frame_end_collide(input logic [7:0] b);
        spi_if.ss = 1'b1;
        spi_if.rx_byte = b;
        spi_if.rx_done = 1'b1;
        @(posedge clk); #1;
        model_end();
        spi_if.rx_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_if.ss = 1'b1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        spi_if.rx_done = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        spi_if.ss = 1'b1;
        spi_if.rx_done = 1'b0;
        spi_if.rx_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        check("lit_reset_tx", spi_if.tx_byte, 8'hA5);
        check("lit_reset_reg0", reg0_q, 8'h00);
        check("lit_reset_busy", {7'd0, busy}, 8'h00);
        frame_start(); sb(8'h0F);
        check("lit_read15", spi_if.tx_byte, 8'h3C);
        frame_end();

        // Burst write 0x12, 0x34 to registers 0 and 1.
        wr_cnt = 0;
        frame_start(); sb(8'h80); sb(8'h12); sb(8'h34); frame_end();
        check("lit_wr_reg0", reg0_q, 8'h12);
        check("lit_wr_reg1", reg1_q, 8'h34);
        check("lit_wr_cnt2", 8'(wr_cnt), 8'd2);
        check("lit_wr_tx", spi_if.tx_byte, 8'hA5);

        frame_start();
        sb(8'h00); check("lit_rd0", spi_if.tx_byte, 8'h12);
        sb(8'hFF); check("lit_rd1", spi_if.tx_byte, 8'h34);
        sb(8'hFF); check("lit_rd2", spi_if.tx_byte, 8'h00);
        sb(8'hFF);
        frame_end();

        // Burst starting at the read-only ID register wraps to register 0.
        wr_cnt = 0;
        frame_start(); sb(8'h8F); sb(8'h55); sb(8'h66); frame_end();
        check("lit_wrap_reg0", reg0_q, 8'h66);
        check("lit_wrap_cnt1", 8'(wr_cnt), 8'd1);
        frame_start(); sb(8'h0F);
        check("lit_id_kept", spi_if.tx_byte, 8'h3C);
        frame_end();

        frame_start(); sb(8'h30); sb(8'h81); sb(8'h22);
        check("lit_err_set", {7'd0, err}, 8'h01);
        check("lit_err_tx", spi_if.tx_byte, 8'hEE);
        frame_end();
        frame_start(); sb(8'h8E); sb(8'h00); frame_end();
        check("lit_err_clr", {7'd0, err}, 8'h00);
        frame_start(); sb(8'h0E);
        check("lit_reg14", spi_if.tx_byte, 8'h00);
        frame_end();

        // Byte completing as ss rises is dropped.
        frame_start(); sb(8'h80); frame_end_collide(8'h77);
        check("lit_collide", reg0_q, 8'h66);

        // Reset in the middle of a burst, coinciding with a byte.
        frame_start(); sb(8'h80); sb(8'h11);
        spi_if.rx_byte = 8'h99;
        spi_if.rx_done = 1'b1;
        do_reset();
        check("lit_rst_tx", spi_if.tx_byte, 8'hA5);
        check("lit_rst_reg0", reg0_q, 8'h00);
        check("lit_rst_err", {7'd0, err}, 8'h00);
        check("lit_rst_wr", {7'd0, wr_pulse}, 8'h00);

        for (int f = 0; f < 80; f++) begin
            int kind, nb;
            logic [7:0] cmd;
            kind = int'($urandom_range(0, 9));
            nb   = int'($urandom_range(0, 5));
            if (kind == 0)
                cmd = {1'($urandom), 3'($urandom_range(1, 7)), 4'($urandom)};
            else if (kind == 1)
                cmd = 8'h8E;
            else
                cmd = {1'($urandom), 3'b000, 4'($urandom)};
            frame_start();
            sb(cmd);
            for (int i = 0; i < nb; i++) begin
                if (kind == 1 || $urandom_range(0, 3) == 0) sb(8'h00);
                else sb(8'($urandom));
            end
            if ($urandom_range(0, 19) == 0) begin
                spi_if.rx_byte = 8'($urandom);
                spi_if.rx_done = 1'($urandom);
                do_reset();
            end else if ($urandom_range(0, 5) == 0) begin
                frame_end_collide(8'($urandom));
            end else begin
                frame_end();
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
